// File: rtl/logic_nor_unit.sv
// Bitwise NOR gate cell: combinational result, a registered copy qualified by
// in_valid, and a saturating count of accepted all-ones results.
module logic_nor_unit #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] nor_ones_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic all_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    logic [WIDTH-1:0]     w_nor;
    logic                 w_ones_hit;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    logic [WIDTH-1:0]     r_y_q;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_cnt;

    // The gate itself stays outside all clocked logic so it works with no clock.
    assign w_nor = ~(a | b);
    assign y     = w_nor;

    // Next counter value: clear wins over increment, increment stops at all-ones.
    always_comb begin
        w_ones_hit = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_ones_hit = in_valid & all_ones(w_nor);
        if (cnt_clr) begin
            w_cnt_nxt = {CNT_WIDTH{1'b0}};
        end else if (w_ones_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Registered copy, valid strobe and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q       <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_cnt       <= {CNT_WIDTH{1'b0}};
        end else begin
            if (in_valid) begin
                r_y_q <= w_nor;
            end else begin
                r_y_q <= r_y_q;
            end
            r_out_valid <= in_valid;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign y_q          = r_y_q;
    assign out_valid    = r_out_valid;
    assign nor_ones_cnt = r_cnt;

endmodule

// File: tb/tb_logic_nor_unit.sv
// Self-checking bench for logic_nor_unit: truth table, directed sequences and
// randomized traffic against a behavioural model on three configurations.
module tb_logic_nor_unit;

    logic clk;
    logic clk_en;

    logic        rst1, a1, b1, v1, clr1, y1, yq1, ov1;
    logic [15:0] cnt1;
    logic        rst2, a2, b2, v2, clr2, y2, yq2, ov2;
    logic [1:0]  cnt2;
    logic        rst4, v4, clr4, ov4;
    logic [3:0]  a4, b4, y4, yq4;
    logic [15:0] cnt4;

    int checks = 0;
    int errors = 0;

    logic_nor_unit #(.WIDTH(1), .CNT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(v1), .cnt_clr(clr1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .nor_ones_cnt(cnt1));

    logic_nor_unit #(.WIDTH(1), .CNT_WIDTH(2)) u2 (
        .clk(clk), .rst(rst2), .a(a2), .b(b2), .in_valid(v2), .cnt_clr(clr2),
        .y(y2), .y_q(yq2), .out_valid(ov2), .nor_ones_cnt(cnt2));

    logic_nor_unit #(.WIDTH(4), .CNT_WIDTH(16)) u4 (
        .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(v4), .cnt_clr(clr4),
        .y(y4), .y_q(yq4), .out_valid(ov4), .nor_ones_cnt(cnt4));

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a;
        logic b;
        logic y;
    } tt_t;

    tt_t tt[4];

    // reference model state for randomized phase
    int         m2_cnt, m4_cnt;
    logic       m2_yq, m2_ov, m4_ov;
    logic [3:0] m4_yq;

    initial begin
        clk_en = 1'b0;
        {rst1, a1, b1, v1, clr1} = 5'b0;
        {rst2, a2, b2, v2, clr2} = 5'b0;
        rst4 = 1'b0; v4 = 1'b0; clr4 = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // truth table, clock stopped
        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b1};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b0};
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            #10;
            chk($sformatf("truth_y[%0d]", i), {31'd0, y1}, {31'd0, tt[i].y});
        end
        a4 = 4'b0101; b4 = 4'b0011;
        #1;
        chk("w4_comb_y", {28'd0, y4}, 32'h8);

        // reset all instances, y stays live during reset
        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1; clr1 = 1'b0;
        clk_en = 1'b1;
        tick(); tick();
        chk("rst_yq", {31'd0, yq1}, 32'd0);
        chk("rst_ov", {31'd0, ov1}, 32'd0);
        chk("rst_cnt", {16'd0, cnt1}, 32'd0);
        chk("rst_y_live", {31'd0, y1}, 32'd1);
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

        // registered path
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        tick();
        chk("reg1_yq", {31'd0, yq1}, 32'd0);
        chk("reg1_ov", {31'd0, ov1}, 32'd1);
        a1 = 1'b0; b1 = 1'b0;
        tick();
        chk("reg2_yq", {31'd0, yq1}, 32'd1);
        chk("reg2_ov", {31'd0, ov1}, 32'd1);
        v1 = 1'b0; a1 = 1'b1;
        tick();
        chk("reg3_ov", {31'd0, ov1}, 32'd0);
        chk("reg3_yq_hold", {31'd0, yq1}, 32'd1);

        // counter with clear priority
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        v1 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; tick();
        a1 = 1'b1; b1 = 1'b1; tick();
        a1 = 1'b0; b1 = 1'b0; tick();
        chk("cnt_two", {16'd0, cnt1}, 32'd2);
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        chk("clr_cnt", {16'd0, cnt1}, 32'd0);
        chk("clr_yq", {31'd0, yq1}, 32'd1);
        chk("clr_ov", {31'd0, ov1}, 32'd1);

        // saturation with CNT_WIDTH=2
        a2 = 1'b0; b2 = 1'b0; v2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_cnt[%0d]", i), {30'd0, cnt2}, (i < 3) ? i + 1 : 3);
        end
        v2 = 1'b0;

        // WIDTH=4
        a4 = 4'b0101; b4 = 4'b0011; v4 = 1'b1;
        tick();
        chk("w4_yq", {28'd0, yq4}, 32'h8);
        chk("w4_cnt0", {16'd0, cnt4}, 32'd0);
        a4 = 4'h0; b4 = 4'h0;
        #1;
        chk("w4_y_ones", {28'd0, y4}, 32'hF);
        tick();
        chk("w4_yq_ones", {28'd0, yq4}, 32'hF);
        chk("w4_cnt1", {16'd0, cnt4}, 32'd1);
        v4 = 1'b0;

        // reset mid-stream
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        tick();
        chk("mid_pre_ov", {31'd0, ov1}, 32'd1);
        rst1 = 1'b1;
        #1;
        chk("mid_y_before", {31'd0, y1}, 32'd1);
        tick();
        rst1 = 1'b0; v1 = 1'b0;
        chk("mid_yq", {31'd0, yq1}, 32'd0);
        chk("mid_ov", {31'd0, ov1}, 32'd0);
        chk("mid_cnt", {16'd0, cnt1}, 32'd0);
        chk("mid_y_after", {31'd0, y1}, 32'd1);

        // randomized traffic on u2 and u4 against the model
        m2_cnt = 0; m4_cnt = 0; m2_yq = 1'b0; m2_ov = 1'b0; m4_yq = 4'h0; m4_ov = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rst2 = (i == 0) || ($urandom_range(0, 24) == 0);
            rst4 = (i == 0) || ($urandom_range(0, 24) == 0);
            v2 = ($urandom_range(0, 3) != 0);
            v4 = ($urandom_range(0, 3) != 0);
            clr2 = ($urandom_range(0, 14) == 0);
            clr4 = ($urandom_range(0, 14) == 0);
            a2 = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'($urandom);
            b2 = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'($urandom);
            a4 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            b4 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            #1;
            chk("rnd_y2", {31'd0, y2}, (a2 == 1'b0 && b2 == 1'b0) ? 32'd1 : 32'd0);
            chk("rnd_y4", {28'd0, y4}, 32'(15 - (int'(a4) | int'(b4))));
            if (rst2) begin
                m2_yq = 1'b0; m2_ov = 1'b0; m2_cnt = 0;
            end else begin
                if (v2) m2_yq = !(a2 || b2);
                m2_ov = v2;
                if (clr2) m2_cnt = 0;
                else if (v2 && !a2 && !b2 && m2_cnt < 3) m2_cnt++;
            end
            if (rst4) begin
                m4_yq = 4'h0; m4_ov = 1'b0; m4_cnt = 0;
            end else begin
                if (v4) m4_yq = 4'(15 - (int'(a4) | int'(b4)));
                m4_ov = v4;
                if (clr4) m4_cnt = 0;
                else if (v4 && a4 == 4'h0 && b4 == 4'h0 && m4_cnt < 65535) m4_cnt++;
            end
            @(posedge clk);
            #1;
            chk("rnd_yq2", {31'd0, yq2}, {31'd0, m2_yq});
            chk("rnd_ov2", {31'd0, ov2}, {31'd0, m2_ov});
            chk("rnd_cnt2", {30'd0, cnt2}, 32'(m2_cnt));
            chk("rnd_yq4", {28'd0, yq4}, {28'd0, m4_yq});
            chk("rnd_ov4", {31'd0, ov4}, {31'd0, m4_ov});
            chk("rnd_cnt4", {16'd0, cnt4}, 32'(m4_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_nor_unit.md
# logic_nor_unit

Bitwise two-input NOR primitive with an immediate combinational output and a one-cycle registered copy, used as a basic gate cell in the digital-electronics block library. A saturating counter tracks how many accepted samples produced an all-ones result, for simple activity checks. The combinational path is independent of clock and reset, so the block can serve as a pure gate.

## Interface
Parameters:
- WIDTH, 1, bit width of operands and results; must be ≥ 1.
- CNT_WIDTH, 16, width of the all-ones event counter; must be ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path and the counter.
- cnt_clr  input  1  synchronous clear of nor_ones_cnt.
- y  output  WIDTH  combinational result, ~(a | b).
- y_q  output  WIDTH  registered result of the last accepted sample.
- out_valid  output  1  high for one cycle after each accepted sample.
- nor_ones_cnt  output  CNT_WIDTH  saturating count of accepted samples where every bit of ~(a | b) is 1.

## Operation
- y = ~(a | b), computed per bit, purely combinational:
  - y changes within the same delta as a and b.
  - Not gated by in_valid, clk or rst.
- For WIDTH=1, the truth table is:
  - a=0, b=0 → y=1
  - a=0, b=1 → y=0
  - a=1, b=0 → y=0
  - a=1, b=1 → y=0
- An input is accepted on a rising edge where in_valid=1 and rst=0.
- On acceptance:
  - y_q ← ~(a | b).
  - out_valid ← 1.
- On a rising edge with in_valid=0:
  - out_valid ← 0.
  - y_q holds its previous value.
- Counter, evaluated on each rising edge with rst=0:
  - cnt_clr=1 → nor_ones_cnt ← 0. This takes priority over an increment in the same cycle; the sample is still accepted into y_q and out_valid.
  - Otherwise, if the sample is accepted and ~(a | b) is all ones (a=0 and b=0), increment by 1.
  - The counter saturates at 2^CNT_WIDTH−1 and never wraps.
- X/Z on a or b is propagated per standard Verilog semantics on y; no special handling.

## Timing
- y: zero-cycle latency. It is valid one propagation delay after a/b settle, including while rst=1 and without any clock edges.
- y_q, out_valid: one-cycle latency. A sample accepted at edge N appears after edge N.
- nor_ones_cnt: reflects a sample accepted at edge N after edge N.
- Back-to-back acceptance is allowed every cycle; there is no backpressure and no ready signal.
- Reset, on a rising edge with rst=1:
  - y_q ← 0, out_valid ← 0, nor_ones_cnt ← 0.
  - Reset overrides in_valid and cnt_clr.
- Before the first clock edge, registered outputs are unspecified; y is already valid.
- Reset asserted mid-stream discards the in-flight sample; out_valid is 0 after that edge.

## Test plan
- Truth table, no clock activity: apply (a,b) = (0,0), (0,1), (1,0), (1,1) with 10 ns spacing. Required y = 1, 0, 0, 0 at each step.
- Registered path: after reset, present a=1, b=0 with in_valid=1 for one edge, then a=0, b=0 with in_valid=1. Required:
  - After the first edge: y_q=0, out_valid=1.
  - After the second edge: y_q=1, out_valid=1.
  - In the next cycle with in_valid=0: out_valid=0 and y_q holds 1.
- Counter: accept three samples (0,0), (1,1), (0,0). Required nor_ones_cnt=2. Then apply cnt_clr=1 together with an accepted (0,0). Required nor_ones_cnt=0 and y_q=1.
- Saturation with CNT_WIDTH=2: accept five (0,0) samples. Required nor_ones_cnt sequence 1, 2, 3, 3, 3.
- WIDTH=4: a=4'b0101, b=4'b0011. Required y=4'b1000. The accepted sample does not increment nor_ones_cnt. Then a=0, b=0 gives y=4'hF and increments the counter.
- Reset mid-stream: hold in_valid=1 and assert rst for one edge with a=0, b=0. Required after that edge: y_q=0, out_valid=0, nor_ones_cnt=0, while y=1 throughout.
